div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one clock, `clk`; reset, `rst`, SHALL be synchronous and active-high.
REQ-002 Ports SHALL be, one per line, name / direction / width / meaning:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- start_valid  in  1  request valid
- start_ready  out  1  request accepted when high with start_valid
- X  in  64  dividend
- Y  in  64  divisor
- Is32Bit  in  1  W-form op on the low 32 bits, sign-extended result
- DivOp  in  4  one-hot: 0001 div, 0010 divu, 0100 rem, 1000 remu
- kill  in  1  pipeline flush; abort the op in flight
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts the result
- OUTPUT  out  64  quotient or remainder
- busy  out  1  high in any state except IDLE

Function
REQ-003 The state machine SHALL have the states IDLE, PREP, ITER, FIX and DONE.
REQ-004 IDLE SHALL drive start_ready=1; on start_valid, it SHALL latch the operands, Is32Bit and DivOp, then go to PREP.
REQ-005 PREP SHALL perform these steps:
- take operand magnitudes for signed ops (div, rem); use raw operands for unsigned ops
- for W-form ops, sign- or zero-extend bit 31 first, per op signedness
- load the iteration count N: 64, or 32 when Is32Bit
REQ-006 ITER SHALL perform one restoring-division step per cycle for N cycles, then go to FIX.
REQ-007 FIX SHALL apply the result signs:
- quotient negated iff the operand signs differ and the divisor is nonzero
- remainder takes the sign of the dividend
REQ-008 FIX SHALL then select the quotient (div/divu) or the remainder (rem/remu), and go to DONE.
REQ-009 For W-form ops, OUTPUT SHALL be {{32{r[31]}}, r[31:0]}.
REQ-010 Timing SHALL be exact: acceptance at edge t; PREP at t+1; ITER t+2..t+N+1; FIX t+N+2; res_valid first high in cycle t+N+3.
REQ-011 DONE SHALL hold res_valid=1 and OUTPUT stable until res_ready; then go to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-012 Divide-by-zero SHALL yield a quotient of all ones and a remainder equal to the (extended) dividend.
REQ-013 Signed overflow (most-negative ÷ −1) SHALL yield quotient = dividend, remainder = 0; 32-bit equivalent for W-form.
REQ-014 kill SHALL return the block to IDLE at the next edge from any state, including DONE, with no res_valid; kill SHALL take priority over start_valid and res_ready in the same cycle.
REQ-015 start_ready SHALL be 0 in every state except IDLE; start_valid SHALL be ignored outside IDLE.
REQ-016 A DivOp that is not one-hot, when accepted, SHALL complete normally with OUTPUT = 0.

Reset
REQ-017 On rst, the block SHALL enter IDLE with busy=0, res_valid=0, start_ready=1, OUTPUT=0, all datapath registers 0 and the count 0.
REQ-018 rst SHALL override kill and all other inputs.
REQ-019 rst mid-operation SHALL discard the op in flight with no result.

Configuration
REQ-020 The macro DIV_SEQ_FASTPATH_EN SHALL control the fast path, as follows.
- Defined: PREP detects divide-by-zero, signed overflow, and |X| < |Y| (unsigned magnitude compare), then jumps directly to DONE; res_valid is high in cycle t+2, with the values of REQ-012 and REQ-013, or quotient 0 and remainder = dividend.
- Undefined: every op takes the full N+3 latency.
REQ-021 OUTPUT SHALL be bit-identical with and without DIV_SEQ_FASTPATH_EN.

Structure
REQ-022 A shared package, mdu_pkg, SHALL hold the DivOp one-hot encodings, the state enum, and the constants XLEN=64, N64=64 and N32=32.
REQ-023 The block SHALL instantiate one combinational sub-module, div_step: remainder/quotient in, shifted trial-subtract result out.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- div X=−7, Y=2 → OUTPUT=0xFFFF_FFFF_FFFF_FFFD; rem, same operands → 0xFFFF_FFFF_FFFF_FFFF; res_valid at t+67 without the macro.
- divu, Y=0, X=5 → OUTPUT=0xFFFF_FFFF_FFFF_FFFF; remu → 5; with the macro, res_valid at t+2.
- div X=0x8000_0000_0000_0000, Y=−1 → quotient = X; rem → 0.
- Is32Bit divu X=0x0000_0000_FFFF_FFFE, Y=1 → 0xFFFF_FFFF_FFFF_FFFE; res_valid at t+35 without the macro.
- kill pulse at ITER cycle 10 → IDLE next cycle, no res_valid; a new request is accepted the cycle after and is correct.
- res_ready held low 5 cycles in DONE → OUTPUT stable, start_ready=0 throughout; release → IDLE.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared divide-unit encodings, FSM states, sizes and result helpers
package mdu_pkg;
    localparam int XLEN = 64;
    localparam int N64  = 64;
    localparam int N32  = 32;
    localparam int CW   = 7;
    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_DIVU = 4'b0010;
    localparam logic [3:0] OP_REM  = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b1000;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;
    // W-form results are the low word sign-extended
    function automatic logic [XLEN-1:0] wfmt(input logic [XLEN-1:0] v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction
    // quotient for div/divu, remainder for rem/remu, zero for a malformed op
    function automatic logic [XLEN-1:0] sel_res(input logic [3:0] op, input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
        return (op == OP_DIV || op == OP_DIVU) ? q : (op == OP_REM || op == OP_REMU) ? r : '0;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on a {remainder, dividend/quotient} pair
module div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            ge;
    // the shifted remainder needs one extra bit when the divisor exceeds 2^63
    assign trial = {rem_i, quo_i[XLEN-1]};
    assign ge    = trial >= {1'b0, div_i};
    assign diff  = trial[XLEN-1:0] - div_i;
    assign rem_o = ge ? diff : trial[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ge};
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential 64/32-bit signed/unsigned divider; DIV_SEQ_FASTPATH_EN enables the early-exit path
module div_seq
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] Y,
    input  logic            Is32Bit,
    input  logic [3:0]      DivOp,
    input  logic            kill,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] OUTPUT,
    output logic            busy
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] x_q, x_d, y_q, y_d, r_q, r_d, q_q, q_d, d_q, d_d, out_q, out_d;
    logic [3:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            w_q, w_d, xneg_q, xneg_d, yneg_q, yneg_d;
    logic            sgn, xn, yn;
    logic [XLEN-1:0] xe, ye, xm, ym, step_r, step_q, qs, rs;

    // operand extension and magnitudes from the latched request
    assign sgn = op_q == OP_DIV || op_q == OP_REM;
    assign xe  = w_q ? {{32{sgn & x_q[31]}}, x_q[31:0]} : x_q;
    assign ye  = w_q ? {{32{sgn & y_q[31]}}, y_q[31:0]} : y_q;
    assign xn  = sgn & xe[XLEN-1];
    assign yn  = sgn & ye[XLEN-1];
    assign xm  = xn ? -xe : xe;
    assign ym  = yn ? -ye : ye;
    assign qs  = (xneg_q ^ yneg_q) && d_q != '0 ? -q_q : q_q;
    assign rs  = xneg_q ? -r_q : r_q;

`ifdef DIV_SEQ_FASTPATH_EN
    logic ovf;
    assign ovf = sgn & yn & (ym == 64'd1) & (xm == (w_q ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000));
`endif

    div_step u_step (
        .rem_i(r_q),
        .quo_i(q_q),
        .div_i(d_q),
        .rem_o(step_r),
        .quo_o(step_q)
    );

    assign start_ready = state_q == IDLE;
    assign res_valid   = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign OUTPUT      = out_q;

    // next-state and datapath updates; kill overrides every transition
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        op_d    = op_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        xneg_d  = xneg_q;
        yneg_d  = yneg_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (start_valid) begin
                x_d     = X;
                y_d     = Y;
                w_d     = Is32Bit;
                op_d    = DivOp;
                state_d = PREP;
            end
            PREP: begin
                xneg_d  = xn;
                yneg_d  = yn;
                r_d     = '0;
                q_d     = w_q ? {xm[31:0], 32'b0} : xm;
                d_d     = ym;
                cnt_d   = w_q ? CW'(N32) : CW'(N64);
                state_d = ITER;
`ifdef DIV_SEQ_FASTPATH_EN
                if (ym == '0 || ovf || xm < ym) begin
                    out_d   = wfmt(sel_res(op_q, ym == '0 ? {XLEN{1'b1}} : ovf ? xe : '0, ovf ? '0 : xe), w_q);
                    state_d = DONE;
                end
`endif
            end
            ITER: begin
                r_d     = step_r;
                q_d     = step_q;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CW'(1) ? FIX : ITER;
            end
            FIX: begin
                out_d   = wfmt(sel_res(op_q, qs, rs), w_q);
                state_d = DONE;
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= 1'b0;
            op_q    <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            xneg_q  <= 1'b0;
            yneg_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            op_q    <= op_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            xneg_q  <= xneg_d;
            yneg_q  <= yneg_d;
            out_q   <= out_d;
        end
    end
endmodule
